// File: rtl/vmc_pkg.sv
// Shared channel indices, coin bit positions and priority-grant helpers for
// the VMC input conditioner.
package vmc_pkg;

  localparam int unsigned N_CH      = 7;
  localparam int unsigned CH_START  = 0;
  localparam int unsigned CH_SELECT = 1;
  localparam int unsigned CH_OK     = 2;
  localparam int unsigned CH_CANCEL = 3;
  localparam int unsigned CH_COIN1  = 4;
  localparam int unsigned CH_COIN5  = 5;
  localparam int unsigned CH_COIN10 = 6;

  localparam int unsigned N_CMD     = 4;
  localparam int unsigned N_COIN    = 3;
  localparam int unsigned COIN_B1   = 0;
  localparam int unsigned COIN_B5   = 1;
  localparam int unsigned COIN_B10  = 2;

  // One-hot grant, CANCEL > OK > SELECT > START.
  function automatic logic [N_CMD-1:0] cmd_grant(input logic [N_CMD-1:0] req);
    cmd_grant = '0;
    if (req[CH_CANCEL])      cmd_grant[CH_CANCEL] = 1'b1;
    else if (req[CH_OK])     cmd_grant[CH_OK]     = 1'b1;
    else if (req[CH_SELECT]) cmd_grant[CH_SELECT] = 1'b1;
    else if (req[CH_START])  cmd_grant[CH_START]  = 1'b1;
  endfunction

  // One-hot grant of the largest coin, 10 > 5 > 1.
  function automatic logic [N_COIN-1:0] coin_grant(input logic [N_COIN-1:0] eff);
    coin_grant = '0;
    if (eff[COIN_B10])     coin_grant[COIN_B10] = 1'b1;
    else if (eff[COIN_B5]) coin_grant[COIN_B5]  = 1'b1;
    else if (eff[COIN_B1]) coin_grant[COIN_B1]  = 1'b1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-channel 2-flop synchronizer plus counter debouncer; rise flags the
// cycle whose closing edge moves level from 0 to 1.
module sw_debounce #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  assign settle = (sync2 != level) && (cnt == CNT_W'(DB_CYCLES - 1));
  // Combinational so the top can register its pulse on the same edge as level.
  assign rise   = settle && sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmc_input_conditioner.sv
// VMC switch front end: per-channel debounce, command arbitration, coin
// serialization and drop counting. Optional SELECT auto-repeat: SWCOND_AUTOREPEAT_EN.
module vmc_input_conditioner
  import vmc_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned CNT_W         = $clog2(DB_CYCLES + 1),
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [N_CH-1:0]   SW_IN,
  output logic              START_P,
  output logic              SELECT_P,
  output logic              OK_P,
  output logic              CANCEL_P,
  output logic              COIN_1_P,
  output logic              COIN_5_P,
  output logic              COIN_10_P,
  output logic [N_CH-1:0]   LEVEL,
  output logic [N_COIN-1:0] COIN_PEND,
  output logic [7:0]        DROP_CNT
);

  if (DB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("vmc_input_conditioner: DB_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   rise;
  logic              rep_fire;
  logic [N_CMD-1:0]  cmd_req;
  logic [N_CMD-1:0]  cmd_gnt;
  logic              cmd_drop;
  logic [N_COIN-1:0] coin_rise;
  logic [N_COIN-1:0] coin_eff;
  logic [N_COIN-1:0] coin_gnt;
  logic              coin_drop;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk   (CLOCK),
      .rst   (RESET),
      .raw   (SW_IN[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  assign LEVEL = level;

`ifdef SWCOND_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] rep_cnt;
  logic             rep_clear;

  assign rep_fire  = level[CH_SELECT] && (rep_cnt == REP_W'(REPEAT_CYCLES - 1));
  // A fresh press, a release or a winning CANCEL/OK restarts the period.
  assign rep_clear = !level[CH_SELECT] || rise[CH_SELECT] || rep_fire ||
                     cmd_gnt[CH_OK] || cmd_gnt[CH_CANCEL];

  always_ff @(posedge CLOCK) begin
    if (RESET || rep_clear) rep_cnt <= '0;
    else                    rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    cmd_req            = rise[N_CMD-1:0];
    cmd_req[CH_SELECT] = rise[CH_SELECT] | rep_fire;
  end

  assign cmd_gnt   = cmd_grant(cmd_req);
  assign cmd_drop  = |(cmd_req & ~cmd_gnt);
  assign coin_rise = rise[CH_COIN10:CH_COIN1];
  assign coin_eff  = COIN_PEND | coin_rise;
  assign coin_gnt  = coin_grant(coin_eff);
  assign coin_drop = |(coin_rise & COIN_PEND);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      {CANCEL_P, OK_P, SELECT_P, START_P} <= '0;
      {COIN_10_P, COIN_5_P, COIN_1_P}     <= '0;
      COIN_PEND                           <= '0;
      DROP_CNT                            <= '0;
    end else begin
      {CANCEL_P, OK_P, SELECT_P, START_P} <= cmd_gnt;
      {COIN_10_P, COIN_5_P, COIN_1_P}     <= coin_gnt;
      COIN_PEND                           <= coin_eff & ~coin_gnt;
      if ((cmd_drop || coin_drop) && (DROP_CNT != '1)) DROP_CNT <= DROP_CNT + 1'b1;
    end
  end

endmodule
